// File: rtl/mult_div_sequencer_if.sv
// Handshake and result bus between the control unit (master) and the
// multiply/divide sequencer (slave).
interface mult_div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) engine
// with HI/LO result registers for the multicycle control unit.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clck,
    input  logic                 reset_n,
    mult_div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MUL_RUN = 3'd1;
    localparam logic [2:0] DIV_RUN = 3'd2;
    localparam logic [2:0] DIV_FIX = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH:0] prod_q, prod_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             isdiv_q, isdiv_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dzo_q, dzo_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_trial;
    logic             div_keep;

    // Operand magnitudes for the divider; -2^(W-1) maps to 2^(W-1) unsigned.
    always_comb begin
        a_mag = bus.a_in[WIDTH-1] ? (~bus.a_in + WIDTH'(1)) : bus.a_in;
        b_mag = bus.b_in[WIDTH-1] ? (~bus.b_in + WIDTH'(1)) : bus.b_in;
    end

    // Booth add/subtract on the upper half, done one bit wider so that a
    // most-negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        booth_sum = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
        case (prod_q[1:0])
            2'b01:   booth_sum = booth_sum + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   booth_sum = booth_sum - {opnd_q[WIDTH-1], opnd_q};
            default: booth_sum = booth_sum;
        endcase
    end

    // Restoring-division trial: the subtraction is kept when it would be
    // non-negative, i.e. when the shifted remainder is >= the divisor.
    always_comb begin
        div_trial = {rem_q, quo_q[WIDTH-1]};
        div_keep  = (div_trial >= {1'b0, opnd_q});
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isdiv_d = isdiv_q;
        dz_d    = dz_q;
        busy_d  = (state_q == MUL_RUN) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
        done_d  = (state_q == DONE);
        dzo_d   = (state_q == DONE) && dz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    isdiv_d = bus.op;
                    dz_d    = 1'b0;
                    if (!bus.op) begin
                        opnd_d  = bus.a_in;
                        prod_d  = {{WIDTH{1'b0}}, bus.b_in, 1'b0};
                        cnt_d   = CW'(WIDTH);
                        state_d = MUL_RUN;
                    end else if (bus.b_in == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        opnd_d  = b_mag;
                        quo_d   = a_mag;
                        rem_d   = '0;
                        negr_d  = bus.a_in[WIDTH-1];
                        negq_d  = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                        cnt_d   = CW'(WIDTH);
                        state_d = DIV_RUN;
                    end
                end
            end
            MUL_RUN: begin
                prod_d = {booth_sum, prod_q[WIDTH:1]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DIV_RUN: begin
                rem_d = div_keep ? (div_trial[WIDTH-1:0] - opnd_q) : div_trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], div_keep};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                quo_d   = negq_q ? (~quo_q + WIDTH'(1)) : quo_q;
                rem_d   = negr_q ? (~rem_q + WIDTH'(1)) : rem_q;
                state_d = DONE;
            end
            DONE: begin
                if (!dz_q) begin
                    hi_d = isdiv_q ? rem_q : prod_q[2*WIDTH:WIDTH+1];
                    lo_d = isdiv_q ? quo_q : prod_q[WIDTH:1];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clck or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            opnd_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isdiv_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            isdiv_q <= isdiv_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dzo_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Iterative signed multiply/divide engine with its own control FSM, serving the MIPS multicycle control unit's mult0/div0 states.
- The control unit pulses start with an opcode and operands, stalls on busy, and branches to the overflow/exception path on div_zero.
- Results are held in internal HI/LO registers, which the control unit's mfhi/mflo paths read.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clck  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = mult (signed), 1 = div (signed)
a_in  input  WIDTH  multiplicand / dividend (rs), latched on accepted start
b_in  input  WIDTH  multiplier / divisor (rt), latched on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; hi_out/lo_out are valid in the same cycle
div_zero  output  1  one-cycle pulse with done when a div has b_in == 0
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register

Behaviour:
- Interface: one clock (clck); reset (reset_n) is asynchronous and active-low.
- Reset values: busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, FSM=IDLE, iteration counter=0, all working registers=0.
- Reset asserted mid-operation aborts immediately and returns every register to its reset value.
- FSM states: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE.
- IDLE, start=1 and op=0: latch a_in/b_in, load counter=WIDTH, go to MUL_RUN.
- IDLE, start=1, op=1, b_in != 0: latch a_in/b_in, take absolute values, record sign(a) and sign(a)^sign(b), go to DIV_RUN.
- IDLE, start=1, op=1, b_in == 0: go to DONE with div_zero flagged. No iteration; HI/LO are unchanged.
- MUL_RUN: radix-2 Booth, one bit per cycle, 2*WIDTH+1-bit product register. Counter decrements each cycle. After WIDTH cycles go to DONE.
- DIV_RUN: restoring division on magnitudes, one quotient bit per cycle. Each cycle, trial-subtract from the shifted-in partial remainder; keep the result if it is non-negative. After WIDTH cycles go to DIV_FIX.
- DIV_FIX, one cycle:
  - negate the quotient if the signs differ;
  - negate the remainder if the dividend was negative;
  - result is truncation toward zero, and the remainder takes the dividend's sign.
- DONE, one cycle: write HI/LO and assert done (plus div_zero if flagged). busy=0. Return to IDLE.
- Result mapping:
  - mult: HI = product[2W-1:W], LO = product[W-1:0].
  - div: LO = quotient, HI = remainder.
- Overflow case -2^(W-1) / -1: LO = 0x80000000, HI = 0. No flag is raised.
- Latency, with the accepted start at rising edge 0:
  - mult: done at edge WIDTH+1 (33);
  - div: done at edge WIDTH+2 (34);
  - div-by-zero: done and div_zero at edge 1.
- busy is high from edge 1 through the edge before DONE. For div-by-zero, busy never asserts.
- start while busy or in DONE is ignored. Operands are not re-sampled.
- start in IDLE on the same edge that DONE exits is impossible, because DONE always lasts one cycle. A start presented during DONE is dropped; the requester must hold start until busy rises or issue it again.
- hi_out/lo_out hold their values between operations and change only in DONE.
- Back-to-back operation: start asserted in the cycle after done is accepted normally.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3) -> busy edges 1..32; done at edge 33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; then mult 0xFFFFFFFF*0xFFFFFFFF -> hi=0, lo=1.
- div a=0xFFFFFFF9 (-7), b=2 -> done at edge 34 with lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
- Preload hi/lo via mult 3*5 (lo=15); then div a=10, b=0 -> done and div_zero at edge 1, busy never high, hi=0, lo=15 unchanged.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0; div 0/5 -> lo=0, hi=0.
- Start mult, pulse start with new operands at edge 10 -> result still matches the original operands. Second run: assert reset_n=0 at edge 15 -> busy, done and hi/lo go to 0 asynchronously; the FSM is back in IDLE and accepts a new start after reset releases.
